// File: rtl/vtg_pkg.sv
// Shared types and the video mode table for the LCD timing mode controller.
package vtg_pkg;

    localparam int MODE_W  = 3;
    localparam int N_MODES = 4;

    typedef struct packed {
        logic [15:0] h_total;
        logic [15:0] h_sync;
        logic [15:0] h_bporch;
        logic [15:0] h_res;
        logic [15:0] v_total;
        logic [15:0] v_sync;
        logic [15:0] v_bporch;
        logic [15:0] v_res;
        logic        hs_pol;
        logic        vs_pol;
    } vtg_timing_t;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        RUN   = 2'd1,
        WAIT  = 2'd2
    } vtg_state_t;

    localparam vtg_timing_t MODE_0 = '{h_total: 16'd1056, h_sync: 16'd128, h_bporch: 16'd88,
                                       h_res: 16'd800, v_total: 16'd525, v_sync: 16'd2,
                                       v_bporch: 16'd32, v_res: 16'd480, hs_pol: 1'b0, vs_pol: 1'b0};
    localparam vtg_timing_t MODE_1 = '{h_total: 16'd800, h_sync: 16'd96, h_bporch: 16'd48,
                                       h_res: 16'd640, v_total: 16'd525, v_sync: 16'd2,
                                       v_bporch: 16'd33, v_res: 16'd480, hs_pol: 1'b0, vs_pol: 1'b0};
    localparam vtg_timing_t MODE_2 = '{h_total: 16'd1344, h_sync: 16'd136, h_bporch: 16'd160,
                                       h_res: 16'd1024, v_total: 16'd635, v_sync: 16'd6,
                                       v_bporch: 16'd23, v_res: 16'd600, hs_pol: 1'b0, vs_pol: 1'b0};
    localparam vtg_timing_t MODE_3 = '{h_total: 16'd1650, h_sync: 16'd40, h_bporch: 16'd220,
                                       h_res: 16'd1280, v_total: 16'd750, v_sync: 16'd5,
                                       v_bporch: 16'd20, v_res: 16'd720, hs_pol: 1'b1, vs_pol: 1'b1};

endpackage

// File: rtl/vtg_mode_rom.sv
// Combinational mode index to timing record lookup; indices past the table flag invalid.
module vtg_mode_rom
    import vtg_pkg::*;
(
    input  logic [MODE_W-1:0] i_idx,
    output vtg_timing_t       o_tim,
    output logic              o_invalid
);

    always_comb begin
        o_tim     = MODE_0;
        o_invalid = 1'b0;
        case (i_idx)
            3'd0:    o_tim = MODE_0;
            3'd1:    o_tim = MODE_1;
            3'd2:    o_tim = MODE_2;
            3'd3:    o_tim = MODE_3;
            default: o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/vtg_mode_ctrl.sv
// Run-time mode controller for syn_gen: owns the timing buses and applies
// mode switches only at a frame boundary, holding the generator in reset meanwhile.
//
// state | meaning
// BLANK | syn_gen held in reset for HOLD_CYC cycles
// RUN   | generator running, requests serviced
// WAIT  | switch accepted, waiting for frame start or timeout
module vtg_mode_ctrl
    import vtg_pkg::*;
#(
    parameter int HOLD_CYC    = 16,
    parameter int TIMEOUT_CYC = 4194304,
    parameter int DEF_MODE    = 0
) (
    input  logic              I_pxl_clk,
    input  logic              I_rst_n,
    input  logic [MODE_W-1:0] I_mode_sel,
    input  logic              I_mode_req,
    input  logic [15:0]       I_src_hres,
    input  logic [15:0]       I_src_vres,
    input  logic              I_vs,
    output logic              O_ack,
    output logic              O_err,
    output logic              O_busy,
    output logic [MODE_W-1:0] O_mode,
    output logic              O_gen_rst_n,
    output logic [15:0]       O_h_total,
    output logic [15:0]       O_h_sync,
    output logic [15:0]       O_h_bporch,
    output logic [15:0]       O_h_res,
    output logic [15:0]       O_v_total,
    output logic [15:0]       O_v_sync,
    output logic [15:0]       O_v_bporch,
    output logic [15:0]       O_v_res,
    output logic [15:0]       O_rd_hres,
    output logic [15:0]       O_rd_vres,
    output logic              O_hs_pol,
    output logic              O_vs_pol,
    output logic [15:0]       O_frame_cnt
);

    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(HOLD_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_TC  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [MODE_W-1:0] DEF_IDX = MODE_W'(DEF_MODE);

    vtg_state_t        r_state, w_state_nxt;
    vtg_timing_t       r_tim, w_tim_nxt;
    logic [MODE_W-1:0] r_mode, w_mode_nxt;
    logic [MODE_W-1:0] r_sel, w_sel_nxt;
    logic              r_gen_rst_n, w_gen_rst_n_nxt;
    logic              r_ack, w_ack_nxt;
    logic              r_err, w_err_nxt;
    logic              r_busy, w_busy_nxt;
    logic [15:0]       r_frame_cnt, w_frame_cnt_nxt;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
    logic [TMO_W-1:0]  r_tmo_cnt, w_tmo_nxt;
    logic              r_from_req, w_from_req_nxt;
    logic              r_armed, w_armed_nxt;
    logic              r_vs_act_d;
    logic [15:0]       r_rd_hres, r_rd_vres;

    logic [MODE_W-1:0] w_rom_idx;
    vtg_timing_t       w_rom_tim;
    logic              w_rom_inv;
    logic              w_vs_act, w_frame_start, w_hold_tc, w_tmo_tc, w_req_ok;

    // One ROM serves reset load, request validation in RUN and the latched switch target.
    assign w_rom_idx = !I_rst_n ? DEF_IDX : ((r_state == RUN) ? I_mode_sel : r_sel);

    vtg_mode_rom u_rom (
        .i_idx     (w_rom_idx),
        .o_tim     (w_rom_tim),
        .o_invalid (w_rom_inv)
    );

    assign w_vs_act      = r_tim.vs_pol ? I_vs : ~I_vs;
    assign w_frame_start = w_vs_act & ~r_vs_act_d & r_gen_rst_n;
    assign w_hold_tc     = (r_hold_cnt == HOLD_TC);
    assign w_tmo_tc      = (r_tmo_cnt == TMO_TC);
    assign w_req_ok      = I_mode_req & ~r_ack & r_armed;

    always_ff @(posedge I_pxl_clk) begin
        if (!I_rst_n) begin
            r_state     <= BLANK;
            r_tim       <= w_rom_tim;
            r_mode      <= DEF_IDX;
            r_sel       <= DEF_IDX;
            r_gen_rst_n <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
            r_hold_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_from_req  <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tim       <= w_tim_nxt;
            r_mode      <= w_mode_nxt;
            r_sel       <= w_sel_nxt;
            r_gen_rst_n <= w_gen_rst_n_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= w_busy_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_from_req  <= w_from_req_nxt;
            r_armed     <= w_armed_nxt;
        end
    end

    always_ff @(posedge I_pxl_clk) begin
        r_vs_act_d <= w_vs_act;
        r_rd_hres  <= (I_src_hres < r_tim.h_res) ? I_src_hres : r_tim.h_res;
        r_rd_vres  <= (I_src_vres < r_tim.v_res) ? I_src_vres : r_tim.v_res;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BLANK:   if (w_hold_tc) w_state_nxt = RUN;
            RUN:     if (w_req_ok && !w_rom_inv && (I_mode_sel != r_mode)) w_state_nxt = WAIT;
            WAIT:    if (w_frame_start || w_tmo_tc) w_state_nxt = BLANK;
            default: w_state_nxt = BLANK;
        endcase
    end

    always_comb begin
        w_tim_nxt       = r_tim;
        w_mode_nxt      = r_mode;
        w_sel_nxt       = r_sel;
        w_gen_rst_n_nxt = r_gen_rst_n;
        w_ack_nxt       = 1'b0;
        w_err_nxt       = 1'b0;
        w_busy_nxt      = r_busy;
        w_frame_cnt_nxt = r_frame_cnt;
        w_hold_nxt      = '0;
        w_tmo_nxt       = '0;
        w_from_req_nxt  = r_from_req;
        // A request is re-armed only once it has been observed low.
        w_armed_nxt     = r_armed | ~I_mode_req;
        case (r_state)
            BLANK: begin
                w_gen_rst_n_nxt = 1'b0;
                w_hold_nxt      = r_hold_cnt + 1'b1;
                if (w_hold_tc) begin
                    w_gen_rst_n_nxt = 1'b1;
                    w_hold_nxt      = '0;
                    w_frame_cnt_nxt = '0;
                    w_ack_nxt       = r_from_req;
                    w_busy_nxt      = 1'b0;
                    w_from_req_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (w_frame_start) w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                if (w_req_ok) begin
                    w_armed_nxt = 1'b0;
                    if (w_rom_inv) begin
                        w_ack_nxt = 1'b1;
                        w_err_nxt = 1'b1;
                    end else if (I_mode_sel == r_mode) begin
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_sel_nxt      = I_mode_sel;
                        w_busy_nxt     = 1'b1;
                        w_from_req_nxt = 1'b1;
                    end
                end
            end
            WAIT: begin
                w_tmo_nxt = r_tmo_cnt + 1'b1;
                if (w_frame_start || w_tmo_tc) begin
                    w_tim_nxt       = w_rom_tim;
                    w_mode_nxt      = r_sel;
                    w_gen_rst_n_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign O_ack       = r_ack;
    assign O_err       = r_err;
    assign O_busy      = r_busy;
    assign O_mode      = r_mode;
    assign O_gen_rst_n = r_gen_rst_n;
    assign O_h_total   = r_tim.h_total;
    assign O_h_sync    = r_tim.h_sync;
    assign O_h_bporch  = r_tim.h_bporch;
    assign O_h_res     = r_tim.h_res;
    assign O_v_total   = r_tim.v_total;
    assign O_v_sync    = r_tim.v_sync;
    assign O_v_bporch  = r_tim.v_bporch;
    assign O_v_res     = r_tim.v_res;
    assign O_hs_pol    = r_tim.hs_pol;
    assign O_vs_pol    = r_tim.vs_pol;
    assign O_rd_hres   = r_rd_hres;
    assign O_rd_vres   = r_rd_vres;
    assign O_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vtg_mode_ctrl.sv
// Bench for vtg_mode_ctrl: table of mode requests with a scoreboard of expected
// completions, plus hand sequences for reset, frame counting and handshake corners.
module tb_vtg_mode_ctrl;

    localparam int HOLD = 16;
    localparam int TMO  = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mode_sel;
    logic        mode_req;
    logic [15:0] src_hres, src_vres;
    logic        vs;
    logic        ack, err, busy, gen_rst_n, hs_pol, vs_pol;
    logic [2:0]  mode;
    logic [15:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
    logic [15:0] rd_hres, rd_vres, frame_cnt;

    always #5 clk = ~clk;

    vtg_mode_ctrl #(.HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO), .DEF_MODE(0)) dut (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_mode_sel(mode_sel), .I_mode_req(mode_req),
        .I_src_hres(src_hres), .I_src_vres(src_vres), .I_vs(vs),
        .O_ack(ack), .O_err(err), .O_busy(busy), .O_mode(mode), .O_gen_rst_n(gen_rst_n),
        .O_h_total(h_total), .O_h_sync(h_sync), .O_h_bporch(h_bporch), .O_h_res(h_res),
        .O_v_total(v_total), .O_v_sync(v_sync), .O_v_bporch(v_bporch), .O_v_res(v_res),
        .O_rd_hres(rd_hres), .O_rd_vres(rd_vres), .O_hs_pol(hs_pol), .O_vs_pol(vs_pol),
        .O_frame_cnt(frame_cnt)
    );

    typedef struct {
        int ht, hsy, hbp, hr, vt, vsy, vbp, vr;
        bit hs, vs;
    } tim_t;

    typedef struct {
        logic [2:0] sel;
        bit         use_vs;
        bit         exp_err;
        bit         exp_sw;
        int         exp_mode;
        tim_t       exp_tim;
    } vec_t;

    typedef struct {
        bit   err;
        bit   sw;
        int   mode;
        tim_t tim;
        int   lat;
        int   sw_cyc;
        int   rst_low;
    } exp_t;

    tim_t T[4];
    vec_t vecs[9];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   cur_pol = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic vec_t mk(input logic [2:0] sel, input bit use_vs, input bit e,
                                input bit sw, input int m);
        vec_t v;
        v.sel = sel; v.use_vs = use_vs; v.exp_err = e; v.exp_sw = sw;
        v.exp_mode = m; v.exp_tim = T[m];
        return v;
    endfunction

    task automatic chk_tim(input string tag, input tim_t t);
        chk({tag, "_h_total"}, int'(h_total), t.ht);
        chk({tag, "_h_sync"}, int'(h_sync), t.hsy);
        chk({tag, "_h_bporch"}, int'(h_bporch), t.hbp);
        chk({tag, "_h_res"}, int'(h_res), t.hr);
        chk({tag, "_v_total"}, int'(v_total), t.vt);
        chk({tag, "_v_sync"}, int'(v_sync), t.vsy);
        chk({tag, "_v_bporch"}, int'(v_bporch), t.vbp);
        chk({tag, "_v_res"}, int'(v_res), t.vr);
        chk({tag, "_hs_pol"}, int'(hs_pol), int'(t.hs));
        chk({tag, "_vs_pol"}, int'(vs_pol), int'(t.vs));
        chk({tag, "_rd_hres"}, int'(rd_hres), min2(int'(src_hres), t.hr));
        chk({tag, "_rd_vres"}, int'(rd_vres), min2(int'(src_vres), t.vr));
    endtask

    // Drive a request, push its expected completion, pop and compare at O_ack.
    task automatic run_req(input string tag, input vec_t v);
        exp_t e;
        int   cyc = 0, low = 0, swc = 0, busy1 = 0;
        bit   got = 1'b0;
        e.err = v.exp_err; e.sw = v.exp_sw; e.mode = v.exp_mode; e.tim = v.exp_tim;
        e.sw_cyc  = v.exp_sw ? (v.use_vs ? 6 : TMO + 1) : 0;
        e.lat     = v.exp_sw ? e.sw_cyc + HOLD : 1;
        e.rst_low = v.exp_sw ? HOLD : 0;
        sb.push_back(e);
        mode_sel = v.sel;
        mode_req = 1'b1;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy1 = int'(busy);
            if (!gen_rst_n) begin
                low++;
                if (swc == 0) swc = cyc;
            end
            if (ack) got = 1'b1;
            else begin
                if (cyc == 3) mode_sel = 3'd5;
                if (v.use_vs && cyc == 5) vs = cur_pol;
                if (v.use_vs && cyc == 7) vs = ~cur_pol;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            chk({tag, "_ack_timeout"}, 0, 1);
        end else begin
            chk({tag, "_ack_lat"}, cyc, e.lat);
            chk({tag, "_err"}, int'(err), int'(e.err));
            chk({tag, "_mode"}, int'(mode), e.mode);
            chk({tag, "_busy_first"}, busy1, int'(e.sw));
            chk({tag, "_busy_at_ack"}, int'(busy), 0);
            chk({tag, "_gen_rst_at_ack"}, int'(gen_rst_n), 1);
            chk({tag, "_rst_low"}, low, e.rst_low);
            chk({tag, "_switch_cyc"}, swc, e.sw_cyc);
            if (e.sw) chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
            chk_tim(tag, e.tim);
        end
        mode_req = 1'b0;
        cur_pol  = e.tim.vs;
        vs       = ~cur_pol;
        @(negedge clk);
        chk({tag, "_ack_single"}, int'(ack), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int low, acks, bseen;
        T[0] = '{1056, 128, 88, 800, 525, 2, 32, 480, 1'b0, 1'b0};
        T[1] = '{800, 96, 48, 640, 525, 2, 33, 480, 1'b0, 1'b0};
        T[2] = '{1344, 136, 160, 1024, 635, 6, 23, 600, 1'b0, 1'b0};
        T[3] = '{1650, 40, 220, 1280, 750, 5, 20, 720, 1'b1, 1'b1};
        vecs[0] = mk(3'd3, 1, 0, 1, 3);
        vecs[1] = mk(3'd3, 0, 0, 0, 3);
        vecs[2] = mk(3'd6, 0, 1, 0, 3);
        vecs[3] = mk(3'd2, 1, 0, 1, 2);
        vecs[4] = mk(3'd0, 1, 0, 1, 0);
        vecs[5] = mk(3'd7, 0, 1, 0, 0);
        vecs[6] = mk(3'd1, 0, 0, 1, 1);
        vecs[7] = mk(3'd1, 0, 0, 0, 1);
        vecs[8] = mk(3'd4, 0, 1, 0, 1);

        rst_n = 1'b0; mode_sel = 3'd0; mode_req = 1'b0;
        src_hres = 16'd1280; src_vres = 16'd720; vs = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_gen_rst_n", int'(gen_rst_n), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        low = 1; acks = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acks += int'(ack);
            if (!gen_rst_n) low++;
            else break;
        end
        chk("rst_hold_len", low, HOLD);
        chk("rst_no_ack", acks, 0);
        chk("rst_busy_after", int'(busy), 0);
        chk_tim("rst", T[0]);

        for (int i = 0; i < 9; i++) run_req($sformatf("vec%0d", i), vecs[i]);

        // Three frame starts in mode 1 (active-low vsync).
        repeat (3) begin
            vs = 1'b0; repeat (2) @(negedge clk);
            vs = 1'b1; repeat (3) @(negedge clk);
        end
        chk("frame_cnt3", int'(frame_cnt), 3);

        // Request held high past its ack is serviced once only.
        mode_sel = 3'd1; mode_req = 1'b1; acks = 0;
        repeat (8) begin @(negedge clk); acks += int'(ack); end
        chk("held_req_acks", acks, 1);
        mode_req = 1'b0;
        @(negedge clk);

        // Reset during WAIT drops the request; held request needs a low cycle.
        mode_sel = 3'd2; mode_req = 1'b1;
        repeat (10) @(negedge clk);
        chk("wait_busy", int'(busy), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("wrst_busy", int'(busy), 0);
        chk("wrst_ack", int'(ack), 0);
        chk("wrst_mode", int'(mode), 0);
        chk("wrst_frame_cnt", int'(frame_cnt), 0);
        rst_n = 1'b1; cur_pol = 1'b0; vs = 1'b1;
        acks = 0; bseen = 0;
        repeat (40) begin
            @(negedge clk);
            acks += int'(ack);
            bseen |= int'(busy);
        end
        chk("wrst_no_ack", acks, 0);
        chk("wrst_no_service", bseen, 0);
        chk("wrst_gen_released", int'(gen_rst_n), 1);
        chk_tim("wrst", T[0]);
        mode_req = 1'b0;
        @(negedge clk);
        run_req("post_rst", mk(3'd2, 1, 0, 1, 2));

        // Read window clamps on either side.
        src_hres = 16'd700; src_vres = 16'd2000;
        @(negedge clk);
        chk("rd_clamp_h", int'(rd_hres), 700);
        chk("rd_clamp_v", int'(rd_vres), 600);
        src_hres = 16'd1024; src_vres = 16'd599;
        @(negedge clk);
        chk("rd_eq_h", int'(rd_hres), 1024);
        chk("rd_eq_v", int'(rd_vres), 599);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
